// File: rtl/arb_pkg.sv
// arb_pkg
// Shared definitions for the round-robin multiplexer arbiter.
//   N_REQ    : number of requesters sharing the multiplexer
//   SEL_W    : width of the encoded select / grant index
//   BURST_W  : width of the per-grant burst counter (ARB_MAXBURST_EN builds)
//   arb_state_t   : IDLE (no grant) / BUSY (grant held)
//   sel_to_onehot : converts an encoded index into a one-hot grant vector
package arb_pkg;

    localparam int N_REQ   = 4;
    localparam int SEL_W   = 2;
    localparam int BURST_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        return N_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Scans the request vector upward (modulo
// N_REQ) beginning at the start index and reports the first set bit.
// Ports:
//   req   in  N_REQ  request vector
//   start in  SEL_W  index examined first
//   found out 1      at least one request is set
//   idx   out SEL_W  index of the first request found (start when none)
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Walk the offsets from farthest to nearest so that the nearest
    // requester overwrites any farther one; the index wraps naturally
    // because the addition is only SEL_W bits wide.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[start + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = start + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin arbiter that owns the select of a 4-to-1 data multiplexer and
// registers the selected word towards a single valid/ready consumer.
// Optional feature: define ARB_MAXBURST_EN to force a grant release after
// MAX_BURST consecutive transfers by the same holder.
// Parameters:
//   WIDTH      data word width
//   MAX_BURST  transfers per grant before a forced release (1..15),
//              only meaningful with ARB_MAXBURST_EN
// Ports:
//   i_Clk             in   1      clock, rising edge
//   i_Rst_n           in   1      asynchronous active-low reset
//   i_Req             in   4      per-source request
//   i_Datos_0..3      in   WIDTH  source data words
//   i_Ready           in   1      consumer accepts o_Salida this cycle
//   o_Gnt             out  4      registered one-hot grant, zero when idle
//   o_Sel             out  2      registered encoded grant index
//   o_Ack             out  4      combinational capture strobe per source
//   o_Salida          out  WIDTH  registered output word
//   o_Valid           out  1      o_Salida holds an unconsumed word
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [3:0]       i_Req,
    input  logic [WIDTH-1:0] i_Datos_0,
    input  logic [WIDTH-1:0] i_Datos_1,
    input  logic [WIDTH-1:0] i_Datos_2,
    input  logic [WIDTH-1:0] i_Datos_3,
    input  logic             i_Ready,
    output logic [3:0]       o_Gnt,
    output logic [1:0]       o_Sel,
    output logic [3:0]       o_Ack,
    output logic [WIDTH-1:0] o_Salida,
    output logic             o_Valid
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic             load;
    logic             hold_req;
    logic             take;
    logic             burst_done;
    logic             rearb;
    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [WIDTH-1:0] mux_word;

    // The output register can accept a word when it is empty or is being
    // drained this very cycle.
    assign load     = ~o_Valid | i_Ready;
    assign hold_req = i_Req[o_Sel];
    assign o_Ack    = o_Gnt & i_Req & {N_REQ{load}};
    assign take     = (state == BUSY) & hold_req & load;

    // From idle the search resumes after the last granted index; on a
    // release it resumes after the current holder, which then comes last.
    assign pick_start = (state == IDLE) ? ptr + SEL_W'(1) : o_Sel + SEL_W'(1);

    rr_pick u_pick (
        .req   (i_Req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        unique case (o_Sel)
            2'd0:    mux_word = i_Datos_0;
            2'd1:    mux_word = i_Datos_1;
            2'd2:    mux_word = i_Datos_2;
            default: mux_word = i_Datos_3;
        endcase
    end

`ifdef ARB_MAXBURST_EN
    logic [BURST_W-1:0] burst_cnt;

    // The holder's MAX_BURST-th capture also releases the grant at the same
    // edge, so the hand-over costs no bubble.
    assign burst_done = take & (burst_cnt == BURST_W'(MAX_BURST - 1));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            burst_cnt <= '0;
        end else if (rearb) begin
            burst_cnt <= '0;
        end else if (take) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    // Arbitrate whenever idle, whenever the holder drops its request, or
    // when the holder has used up its burst allowance.
    assign rearb = (state == IDLE) | ~hold_req | burst_done;

    // Grant / state register. A release re-arbitrates at the same edge so a
    // waiting requester is granted without an idle cycle in between.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
            ptr   <= SEL_W'(N_REQ - 1);
            o_Gnt <= '0;
            o_Sel <= '0;
        end else if (rearb) begin
            if (pick_found) begin
                state <= BUSY;
                ptr   <= pick_idx;
                o_Sel <= pick_idx;
                o_Gnt <= sel_to_onehot(pick_idx);
            end else begin
                state <= IDLE;
                o_Gnt <= '0;
            end
        end
    end

    // Output stage: capture on an ack, otherwise drop valid once consumed.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Salida <= '0;
            o_Valid  <= 1'b0;
        end else if (take) begin
            o_Salida <= mux_word;
            o_Valid  <= 1'b1;
        end else if (i_Ready) begin
            o_Valid  <= 1'b0;
        end
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares the 4-to-1 data multiplexer among four requesters. It owns the select line, grants one requester at a time, and captures the selected word into a registered output stage. The output stage uses a valid/ready handshake towards a single consumer. It sits between the four data sources and the downstream consumer, replacing a free-running external select.

## Interface
Parameters:
- WIDTH, 4, width of each data word.
- MAX_BURST, 4, maximum consecutive transfers per grant; only used when ARB_MAXBURST_EN is defined; legal range 1..15.

Ports:
- i_Clk  in  1  single clock; all state updates on the rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Req  in  4  request per source; bit k belongs to i_Datos_k.
- i_Datos_0 .. i_Datos_3  in  WIDTH each  source data words.
- i_Ready  in  1  consumer can accept o_Salida this cycle.
- o_Gnt  out  4  one-hot grant, registered; all zeros when idle.
- o_Sel  out  2  encoded index of the granted source, registered.
- o_Ack  out  4  combinational; o_Ack[k] = o_Gnt[k] & i_Req[k] & load; source k's word is captured at this edge.
- o_Salida  out  WIDTH  registered output word.
- o_Valid  out  1  registered; o_Salida holds an unconsumed word.

## Operation
- Load condition: load = ~o_Valid | i_Ready.
- States: IDLE (no grant) and BUSY (grant held by o_Sel).
- IDLE: if i_Req != 0, go to BUSY at the next edge.
  - The granted source is the first requester found searching upward (mod 4) from ptr+1.
  - ptr holds the last granted index.
  - Else stay in IDLE.
- BUSY:
  - If i_Req[o_Sel] = 1 and load: o_Salida <= selected i_Datos, o_Valid <= 1, and the o_Ack bit pulses.
  - If i_Req[o_Sel] = 1 and not load: hold everything.
  - If i_Req[o_Sel] = 0: release. Re-arbitrate at the same edge, searching from o_Sel+1.
    - Any requester found: stay BUSY with the new grant, zero idle cycles.
    - None found: go to IDLE with o_Gnt = 0.
- ptr updates to the new index on every grant.
- Output stage: if i_Ready and o_Valid and there is no new load, o_Valid <= 0.
- o_Salida keeps its last value when not loaded.
- Simultaneous release and load in one cycle cannot occur: ack requires i_Req[o_Sel] = 1.
- Grant switches happen only at the edge; o_Sel and o_Gnt are always consistent.

## Timing
- Reset values:
  - state = IDLE, ptr = 3 (first priority goes to source 0).
  - o_Gnt = 0, o_Sel = 0, o_Salida = 0, o_Valid = 0.
  - o_Ack = 0, since o_Gnt = 0.
- Latency from an idle start:
  - Request sampled at edge 1 → o_Gnt valid after edge 1.
  - o_Ack is high in the cycle after edge 1, when the output is free.
  - o_Valid is high after edge 2.
- Steady-state throughput: one word per cycle while i_Ready = 1 and the granted request stays asserted.
- Backpressure: with i_Ready = 0 and o_Valid = 1, o_Salida, o_Valid, o_Gnt and o_Sel are frozen and o_Ack = 0.
- Reset mid-operation clears everything immediately; any word held in the output register is lost.

## Configuration
- ARB_MAXBURST_EN defined:
  - A burst counter (4 bits) counts o_Ack pulses of the current holder and resets on every new grant.
  - When the MAX_BURST-th ack occurs, the grant is forcibly released at that edge.
  - Re-arbitration starts from o_Sel+1. The previous holder is re-granted only if it is the only requester; the counter then resets.
- ARB_MAXBURST_EN undefined: no counter; the holder keeps the grant until its request drops, and MAX_BURST is ignored.

## Structure
- Shared package arb_pkg:
  - N_REQ = 4 and SEL_W = 2.
  - State encoding: IDLE = 1'b0, BUSY = 1'b1.
  - Burst counter width = 4.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: 4-bit request vector and 2-bit start index.
  - Outputs: found flag and 2-bit index.
- rr_pick is used for both the IDLE and the release arbitration paths.

## Test plan
- Reset: assert i_Rst_n = 0 mid-transfer → all outputs zero asynchronously. After release with i_Req = 4'b0000, the block stays IDLE and o_Gnt = 0.
- Single source: i_Req = 4'b0100, i_Datos_2 = 4'b1100, i_Ready = 1 → o_Gnt = 4'b0100 and o_Sel = 2 after edge 1; o_Salida = 4'b1100 and o_Valid = 1 after edge 2.
- Rotation: i_Req = 4'b1111, each source drops its request after one ack → grant order 0, 1, 2, 3, 0; no idle cycle between grants.
- Backpressure: while holding source 1, i_Ready = 0 for 3 cycles → o_Salida, o_Valid, o_Gnt stable and o_Ack = 0. After i_Ready = 1, transfers resume with no lost or duplicated word.
- Burst limit (ARB_MAXBURST_EN, MAX_BURST = 4), i_Req = 4'b0011 held:
  - Source 0 gets exactly 4 acks, then source 1 gets 4 acks, then source 0 again.
  - Without the macro, source 0 keeps the grant indefinitely.
- Release to idle: the only requester (source 3, i_Datos_3 = 4'b1111) drops its request → o_Gnt = 0 at the next edge. o_Valid clears once i_Ready consumes the last word.
